// File: rtl/inst_fetch_align_pkg.sv
// Shared constants, fetch-state encoding and byte-select helpers for the
// instruction fetch/align block.
package inst_fetch_align_pkg;

  localparam int WORD_W     = 32;
  localparam int INST_BYTES = 10;
  localparam int INST_W     = INST_BYTES * 8;
  localparam int NUM_WORDS  = 4;
  localparam int WIN_BYTES  = NUM_WORDS * (WORD_W / 8);
  localparam int WIN_W      = WIN_BYTES * 8;
  localparam int OFF_W      = 2;
  localparam int BEAT_W     = 2;
  localparam int BYTE_IDX_W = 4;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_WORDS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  // Bit position of the least significant bit of window byte idx.
  function automatic logic [BYTE_IDX_W+2:0] byte_lsb(input logic [BYTE_IDX_W-1:0] idx);
    return {idx, 3'b000};
  endfunction

endpackage

// File: rtl/inst_fetch_align_byte_align_mux.sv
// Combinational byte aligner: picks 10 consecutive bytes out of a 16-byte
// little-endian window, starting at a 2-bit offset. Output byte 0 (the byte
// at the fetch PC) lands in the most significant position.
module byte_align_mux
  import inst_fetch_align_pkg::*;
(
  input  logic [WIN_W-1:0]  win_i,
  input  logic [OFF_W-1:0]  off_i,
  output logic [INST_W-1:0] inst_o
);

  genvar gi;
  generate
    for (gi = 0; gi < INST_BYTES; gi++) begin : g_byte
      logic [BYTE_IDX_W-1:0] idx;
      // Offset 3 plus output byte 9 reaches window byte 12, well inside 16.
      assign idx = BYTE_IDX_W'(gi) + {{(BYTE_IDX_W-OFF_W){1'b0}}, off_i};
      assign inst_o[8*(INST_BYTES-1-gi) +: 8] = win_i[byte_lsb(idx) +: 8];
    end
  endgenerate

endmodule

// File: rtl/inst_fetch_align.sv
// Instruction fetch/align unit: fetches the four aligned ROM words covering
// the instruction window for pc_i, holds them, and presents the byte-aligned
// instruction. A PC within the held word-aligned base is served with no ROM
// traffic.
module inst_fetch_align
  import inst_fetch_align_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] pc_i,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              rom_req_o,
  output logic [WORD_W-1:0] rom_addr_o,
  input  logic              rom_ack_i,
  input  logic [WORD_W-1:0] rom_rdata_i
);

  fetch_state_e state_q, state_d;
  logic [WORD_W-1:0] base_q, base_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              held_q, held_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0] words_q, words_d;
  logic [NUM_WORDS-1:0] word_we;

  logic              pc_hit;
  logic [WORD_W-1:0] pc_base;

  // The PC's base is compared against the base under fetch or held; the live
  // pc_i is the latest PC, so no separate PC copy is needed to track it.
  assign pc_base = {pc_i[WORD_W-1:2], 2'b00};
  assign pc_hit  = (pc_i[WORD_W-1:2] == base_q[WORD_W-1:2]);

  // Next-state, base/beat bookkeeping and per-word write enables.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    held_d  = held_q;
    word_we = '0;
    case (state_q)
      ST_IDLE: begin
        if (!(held_q && pc_hit)) begin
          state_d = ST_FETCH;
          base_d  = pc_base;
          beat_d  = '0;
          held_d  = 1'b0;
        end
      end
      ST_FETCH: begin
        if (rom_ack_i) begin
          if (!pc_hit) begin
            // PC moved to another base while this beat was outstanding: the
            // beat is allowed to finish, its data is dropped, and fetching
            // restarts at the new base on the next cycle.
            base_d = pc_base;
            beat_d = '0;
          end else begin
            word_we[beat_q] = 1'b1;
            if (beat_q == LAST_BEAT) begin
              held_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign words_d[gi] = word_we[gi] ? rom_rdata_i : words_q[gi];
    end
  endgenerate

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      held_q  <= held_d;
    end
  end

  // Held instruction window storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_q <= '0;
    end else begin
      words_q <= words_d;
    end
  end

  // ROM port is driven purely from registered state, so it only moves on
  // clock edges and stays stable while a beat waits for its ack.
  always_comb begin
    rom_req_o  = (state_q == ST_FETCH);
    rom_addr_o = '0;
    if (state_q == ST_FETCH) begin
      rom_addr_o = base_q + {{(WORD_W-BEAT_W-2){1'b0}}, beat_q, 2'b00};
    end
  end

  assign inst_valid_o = held_q && (state_q == ST_IDLE) && pc_hit;

  byte_align_mux u_align (
    .win_i  (words_q),
    .off_i  (pc_i[OFF_W-1:0]),
    .inst_o (inst_o)
  );

endmodule

// File: tb/tb_inst_fetch_align.sv
// Directed bench for inst_fetch_align with a behavioural ROM responder and an
// address scoreboard of expected ROM beats.
module tb_inst_fetch_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = 32'h0;
  logic [79:0] inst_o;
  logic        inst_valid_o;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_rdata_i;

  int total = 0;
  int bad   = 0;
  int wait_cfg = 0;
  int wait_cnt = 0;
  logic ack_force = 1'b0;
  logic [31:0] exp_q[$];

  inst_fetch_align dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_ack_i    (rom_ack_i),
    .rom_rdata_i  (rom_rdata_i)
  );

  always #5 clk = ~clk;

  // ROM content: the byte stored at address a is a[7:0].
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [31:0] w;
    logic [31:0] a;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      a = addr + 32'(k);
      w[8*k +: 8] = a[7:0];
    end
    return w;
  endfunction

  function automatic logic [79:0] exp_inst(input logic [31:0] pc);
    logic [79:0] r;
    logic [31:0] a;
    r = '0;
    for (int j = 0; j < 10; j++) begin
      a = pc + 32'(j);
      r[8*(9-j) +: 8] = a[7:0];
    end
    return r;
  endfunction

  always_comb rom_ack_i   = (rom_req_o && (wait_cnt == wait_cfg)) || ack_force;
  always_comb rom_rdata_i = rom_word(rom_addr_o);

  always @(posedge clk) begin
    if (rom_req_o && !rom_ack_i) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push4(input logic [31:0] base);
    for (int k = 0; k < 4; k++) exp_q.push_back(base + 32'(4*k));
  endtask

  // Count cycles (negedges) from the current one until inst_valid_o rises.
  task automatic wait_valid(input int max, output int lat);
    lat = -1;
    for (int k = 0; k <= max; k++) begin
      @(negedge clk);
      if (inst_valid_o === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Scoreboard: every requested beat must match the next expected address,
  // including while it waits; an acked beat retires that entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rom_req_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("req_not_expected", {79'b0, rom_req_o}, 80'd0);
        end else begin
          chk("rom_addr", {48'b0, rom_addr_o}, {48'b0, exp_q[0]});
          if (rom_ack_i) begin
            $display("beat addr=%h data=%h", rom_addr_o, rom_rdata_i);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int lat;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_req",   {79'b0, rom_req_o}, 80'd0);
    chk("rst_valid", {79'b0, inst_valid_o}, 80'd0);
    chk("rst_addr",  {48'b0, rom_addr_o}, 80'd0);
    chk("rst_inst",  inst_o, 80'd0);

    // Cold miss at 0x0, zero-wait ROM.
    @(posedge clk); #1;
    rst = 1'b1; pc_i = 32'h0; push4(32'h0);
    wait_valid(20, lat);
    chk("lat_pc0", 80'(lat), 80'd5);
    chk("inst_pc0", inst_o, 80'h00010203040506070809);
    $display("txn pc=%h lat=%0d inst=%h", pc_i, lat, inst_o);

    // Offset changes within the held base are same-cycle hits.
    for (int o = 1; o < 4; o++) begin
      @(posedge clk); #1;
      pc_i = 32'(o);
      @(negedge clk);
      chk("hit_valid", {79'b0, inst_valid_o}, 80'd1);
      chk("hit_req",   {79'b0, rom_req_o}, 80'd0);
      chk("hit_inst",  inst_o, exp_inst(32'(o)));
      $display("txn pc=%h hit inst=%h", pc_i, inst_o);
    end

    // Miss at 0x10 with one wait state per beat.
    @(posedge clk); #1;
    wait_cfg = 1; pc_i = 32'h10; push4(32'h10);
    wait_valid(40, lat);
    chk("lat_pc10", 80'(lat), 80'd9);
    chk("inst_pc10", inst_o, exp_inst(32'h10));
    $display("txn pc=%h lat=%0d inst=%h", pc_i, lat, inst_o);

    // PC moves 0x0 -> 0x20 while the third beat (0x8) is outstanding.
    @(posedge clk); #1;
    pc_i = 32'h0;
    push4(32'h0);
    exp_q.pop_back();
    push4(32'h20);
    repeat (5) @(posedge clk);
    #1;
    chk("redir_req",  {79'b0, rom_req_o}, 80'd1);
    chk("redir_addr", {48'b0, rom_addr_o}, 80'h8);
    chk("redir_left", 80'(exp_q.size()), 80'd5);
    pc_i = 32'h20;
    wait_valid(40, lat);
    chk("lat_redir", 80'(lat), 80'd10);
    chk("inst_pc20", inst_o, exp_inst(32'h20));
    $display("txn pc=%h lat=%0d inst=%h", pc_i, lat, inst_o);

    // Address wrap at the top of the address space.
    @(posedge clk); #1;
    wait_cfg = 0; pc_i = 32'hFFFF_FFFE;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    wait_valid(20, lat);
    chk("lat_wrap", 80'(lat), 80'd5);
    chk("inst_wrap", inst_o, 80'hFEFF0001020304050607);
    $display("txn pc=%h lat=%0d inst=%h", pc_i, lat, inst_o);

    // Reset during beat 2 of a fetch at 0x40.
    @(posedge clk); #1;
    pc_i = 32'h40;
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_addr", {48'b0, rom_addr_o}, 80'h48);
    rst = 1'b0; ack_force = 1'b1;
    #1;
    chk("arst_req",   {79'b0, rom_req_o}, 80'd0);
    chk("arst_valid", {79'b0, inst_valid_o}, 80'd0);
    chk("arst_addr",  {48'b0, rom_addr_o}, 80'd0);
    chk("arst_inst",  inst_o, 80'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; pc_i = 32'h0; push4(32'h0);
    @(negedge clk);
    chk("rel_req", {79'b0, rom_req_o}, 80'd0);
    @(posedge clk); #1;
    ack_force = 1'b0;
    wait_valid(20, lat);
    chk("lat_rel", 80'(lat), 80'd4);
    chk("inst_rel", inst_o, exp_inst(32'h0));
    $display("txn pc=%h after reset lat=%0d inst=%h", pc_i, lat, inst_o);

    repeat (3) @(negedge clk);
    chk("idle_req", {79'b0, rom_req_o}, 80'd0);
    chk("beats_all_seen", 80'(exp_q.size()), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
